motcomp_dctcmd_gen: RTL and testbench

Generates the per-macroblock DCT reordering command stream consumed by the motion-compensation DCT-type converter. For each 4:2:0 macroblock descriptor it pushes three commands (one luminance command covering 4 blocks, then Cb and Cr chrominance commands) into an internal command FIFO. The FIFO's read side is exposed as the dct_block empty/en/valid interface. The block sits between the macroblock-mode parser and the DCT-type converter.

---
 rtl/motcomp_dctcmd_gen.sv | 155 +++++++++++++++
 tb/tb_motcomp_dctcmd_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motcomp_dctcmd_gen.sv
// Per-macroblock DCT reorder command generator: reads one 4:2:0 descriptor and queues
// its luma, Cb and Cr commands into a small command FIFO for the DCT-type converter.
module motcomp_dctcmd_gen #(
  parameter int cmd_fifo_addr_width = 4,
  parameter int cmd_fifo_thresh     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       mb_empty,
  output logic       mb_en,
  input  logic       mb_valid,
  input  logic       mb_dct_type,
  input  logic       mb_field_order,
  output logic       dct_block_empty,
  output logic [2:0] dct_block_cmd,
  input  logic       dct_block_en,
  output logic       dct_block_valid,
  output logic       dct_cmd_overflow
);

  localparam int AW = cmd_fifo_addr_width;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FIFO_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FIFO_THRESH = (AW+1)'(cmd_fifo_thresh);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  localparam logic [2:0] DCT_C1_PASS               = 3'd1;
  localparam logic [2:0] DCT_C1_FRAME_TO_TOP_FIELD = 3'd2;
  localparam logic [2:0] DCT_L4_PASS               = 3'd3;
  localparam logic [2:0] DCT_L4_TOP_FIELD_TO_FRAME = 3'd4;
  localparam logic [2:0] DCT_L4_FRAME_TO_TOP_FIELD = 3'd5;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_EN = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WR_L  = 3'd3;
  localparam logic [2:0] WR_CB = 3'd4;
  localparam logic [2:0] WR_CR = 3'd5;

  function automatic logic [2:0] luma_cmd(input logic dct_type, input logic field_order);
    logic [2:0] cmd;
    cmd = DCT_L4_PASS;
    if (dct_type && !field_order)
      cmd = DCT_L4_TOP_FIELD_TO_FRAME;
    else if (!dct_type && field_order)
      cmd = DCT_L4_FRAME_TO_TOP_FIELD;
    return cmd;
  endfunction

  function automatic logic [2:0] chroma_cmd(input logic field_order);
    return field_order ? DCT_C1_FRAME_TO_TOP_FIELD : DCT_C1_PASS;
  endfunction

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic          mb_en_q;
  logic          dct_type_p0;
  logic          field_order_p0;
  logic [2:0]    wr_cmd_d;
  logic          wr_vld_p1;
  logic [2:0]    wr_cmd_p1;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   occupancy;
  logic          prog_full;
  logic          fifo_full;
  logic          fifo_wr;
  logic          fifo_rd;

  // A write still sitting in the p1 register counts against admission.
  assign occupancy = count + (AW+1)'(wr_vld_p1);
  assign prog_full = (occupancy >= FIFO_THRESH);
  assign fifo_full = (count == FIFO_DEPTH);
  assign dct_block_empty = (count == '0);
  assign fifo_wr = wr_vld_p1 && clk_en && !fifo_full;
  assign fifo_rd = dct_block_en && !dct_block_empty;
  assign mb_en = mb_en_q && clk_en;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!mb_empty && !prog_full) next_state = RD_EN;
      RD_EN:   next_state = READ;
      READ:    if (mb_valid) next_state = WR_L;
      WR_L:    next_state = WR_CB;
      WR_CB:   next_state = WR_CR;
      WR_CR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_cmd_d = chroma_cmd(field_order_p0);
    if (state == WR_L)
      wr_cmd_d = luma_cmd(dct_type_p0, field_order_p0);
  end

  // Stage p0: sequencer and descriptor strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mb_en_q   <= 1'b0;
      wr_vld_p1 <= 1'b0;
    end else if (clk_en) begin
      state     <= next_state;
      mb_en_q   <= (state == IDLE) && (next_state == RD_EN);
      wr_vld_p1 <= (state == WR_L) || (state == WR_CB) || (state == WR_CR);
    end
  end

  // Stage p1: latched descriptor fields, registered write command and FIFO storage
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (state == READ && mb_valid) begin
        dct_type_p0    <= mb_dct_type;
        field_order_p0 <= mb_field_order;
      end
      wr_cmd_p1 <= wr_cmd_d;
    end
    if (fifo_wr)
      mem[wr_ptr] <= wr_cmd_p1;
  end

  // Stage p2: FIFO pointers and read port, read side runs regardless of clk_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      dct_block_valid  <= 1'b0;
      dct_block_cmd    <= 3'd0;
      dct_cmd_overflow <= 1'b0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_rd) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        dct_block_cmd <= mem[rd_ptr];
      end
      dct_block_valid <= fifo_rd;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_vld_p1 && clk_en && fifo_full)
        dct_cmd_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_motcomp_dctcmd_gen.sv
// Bench for motcomp_dctcmd_gen: descriptor source plus expected-command queue model,
// compared against every command the DUT hands out.
`timescale 1ns/1ps
module tb_motcomp_dctcmd_gen;

  localparam logic [2:0] C1_PASS = 3'd1;
  localparam logic [2:0] C1_F2T  = 3'd2;
  localparam logic [2:0] L4_PASS = 3'd3;
  localparam logic [2:0] L4_T2F  = 3'd4;
  localparam logic [2:0] L4_F2T  = 3'd5;

  typedef struct packed { logic dt; logic fo; } desc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  logic       mb_empty = 1'b1;
  logic       mb_en;
  logic       mb_valid = 1'b0;
  logic       mb_dct_type = 1'b0;
  logic       mb_field_order = 1'b0;
  logic       dct_block_empty;
  logic [2:0] dct_block_cmd;
  logic       dct_block_en = 1'b0;
  logic       dct_block_valid;
  logic       dct_cmd_overflow;

  int checks = 0;
  int errors = 0;

  desc_t      desc_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  logic [2:0] want[$];
  int         mb_cyc[$];
  int         mb_en_cnt = 0;
  int         cycle = 0;
  int         late = 0;
  int         wait_cnt = 0;
  logic       pend_dt = 1'b0;
  logic       pend_fo = 1'b0;
  bit         en_rand = 1'b0;
  bit         rd_on = 1'b0;
  int         rd_pct = 100;
  int         rd_req = 0;
  int         rd_done = 0;
  desc_t      d_src;

  motcomp_dctcmd_gen #(
    .cmd_fifo_addr_width(4),
    .cmd_fifo_thresh(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .mb_empty(mb_empty),
    .mb_en(mb_en),
    .mb_valid(mb_valid),
    .mb_dct_type(mb_dct_type),
    .mb_field_order(mb_field_order),
    .dct_block_empty(dct_block_empty),
    .dct_block_cmd(dct_block_cmd),
    .dct_block_en(dct_block_en),
    .dct_block_valid(dct_block_valid),
    .dct_cmd_overflow(dct_cmd_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [2:0] luma_of(input logic dt, input logic fo);
    if (dt && !fo) return L4_T2F;
    if (!dt && fo) return L4_F2T;
    return L4_PASS;
  endfunction

  function automatic logic [2:0] chroma_of(input logic fo);
    return fo ? C1_F2T : C1_PASS;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Upstream descriptor FIFO: pops on mb_en, answers with mb_valid one clk_en cycle later
  // (or 'late' clk_en cycles later), and records the three commands the descriptor implies.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_valid <= 1'b0;
      wait_cnt <= 0;
      exp_q.delete();
    end else if (clk_en) begin
      mb_valid <= 1'b0;
      if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
        if (wait_cnt == 1) begin
          mb_valid       <= 1'b1;
          mb_dct_type    <= pend_dt;
          mb_field_order <= pend_fo;
        end
      end
      if (mb_en) begin
        mb_en_cnt <= mb_en_cnt + 1;
        mb_cyc.push_back(cycle);
        if (desc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mb_en_source: got read strobe expected none (descriptor FIFO empty)");
        end else begin
          d_src = desc_q.pop_front();
          exp_q.push_back(luma_of(d_src.dt, d_src.fo));
          exp_q.push_back(chroma_of(d_src.fo));
          exp_q.push_back(chroma_of(d_src.fo));
          if (late == 0) begin
            mb_valid       <= 1'b1;
            mb_dct_type    <= d_src.dt;
            mb_field_order <= d_src.fo;
          end else begin
            pend_dt  <= d_src.dt;
            pend_fo  <= d_src.fo;
            wait_cnt <= late;
          end
        end
      end
    end
  end

  always @(negedge clk) mb_empty <= (desc_q.size() == 0);

  // Input drivers: clock enable pattern and consumer read strobe.
  initial forever begin
    @(posedge clk);
    #1;
    clk_en = en_rand ? 1'($urandom_range(1)) : 1'b1;
    if (rd_done < rd_req) begin
      dct_block_en = 1'b1;
      rd_done++;
    end else begin
      dct_block_en = rd_on && ($urandom_range(99) < rd_pct);
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst) begin
      if (dct_block_valid) begin
        got_q.push_back(dct_block_cmd);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd: got %0d expected no command", dct_block_cmd);
        end else begin
          check("cmd", {29'd0, dct_block_cmd}, {29'd0, exp_q.pop_front()});
        end
      end
      check("overflow", {31'd0, dct_cmd_overflow}, 32'd0);
      if (!clk_en) check("mb_en_gated", {31'd0, mb_en}, 32'd0);
    end
  end

  task automatic push(input logic dt, input logic fo);
    desc_t d;
    d.dt = dt;
    d.fo = fo;
    desc_q.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((desc_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d descriptors, %0d commands outstanding expected 0", name,
               desc_q.size(), exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_mb_en(input string name, input int budget);
    int n;
    n = 0;
    while (mb_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_mb_en_seen"}, {31'd0, mb_en}, 32'd1);
  endtask

  task automatic check_seq(input string name, input int base);
    check({name, "_count"}, got_q.size() - base, want.size());
    for (int i = 0; i < want.size(); i++)
      if (base + i < got_q.size())
        check($sformatf("%s[%0d]", name, i), {29'd0, got_q[base+i]}, {29'd0, want[i]});
  endtask

  initial begin
    int base;
    int mbase;
    int lat;

    // Reset and idle
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_empty", {31'd0, dct_block_empty}, 32'd1);
    check("rst_valid", {31'd0, dct_block_valid}, 32'd0);
    check("rst_cmd", {29'd0, dct_block_cmd}, 32'd0);
    check("rst_overflow", {31'd0, dct_cmd_overflow}, 32'd0);
    check("rst_mb_en", {31'd0, mb_en}, 32'd0);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_mb_en_count", mb_en_cnt, 0);
    check("idle_empty", {31'd0, dct_block_empty}, 32'd1);

    // Mapping sweep, clk_en always high
    rd_on = 1'b1;
    rd_pct = 100;
    base = got_q.size();
    mbase = mb_en_cnt;
    push(0, 0); push(1, 0); push(0, 1); push(1, 1);
    wait_mb_en("sweep", 20);
    lat = 0;
    while (dct_block_empty === 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency_le_4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    wait_drain("sweep", 300);
    want = '{L4_PASS, C1_PASS, C1_PASS, L4_T2F, C1_PASS, C1_PASS,
             L4_F2T, C1_F2T, C1_F2T, L4_PASS, C1_F2T, C1_F2T};
    check_seq("sweep", base);
    check("sweep_mb_en_pulses", mb_en_cnt - mbase, 4);
    if (mb_cyc.size() >= mbase + 2)
      check("throughput", mb_cyc[mbase+1] - mb_cyc[mbase], 6);

    // Same sweep with clk_en toggling
    en_rand = 1'b1;
    base = got_q.size();
    mbase = mb_en_cnt;
    push(0, 0); push(1, 0); push(0, 1); push(1, 1);
    wait_drain("sweep_clken", 800);
    check_seq("sweep_clken", base);
    check("sweep_clken_mb_en_pulses", mb_en_cnt - mbase, 4);
    en_rand = 1'b0;

    // Late mb_valid
    late = 3;
    base = got_q.size();
    mbase = mb_en_cnt;
    push(0, 1);
    wait_drain("late", 200);
    want = '{L4_F2T, C1_F2T, C1_F2T};
    check_seq("late", base);
    check("late_mb_en_pulses", mb_en_cnt - mbase, 1);
    late = 0;

    // Backpressure: no reads, then one read, then drain
    rd_on = 1'b0;
    repeat (4) @(negedge clk);
    mbase = mb_en_cnt;
    for (int i = 0; i < 10; i++) push(1'($urandom_range(1)), 1'($urandom_range(1)));
    repeat (80) @(negedge clk);
    check("bp_accepted_full", mb_en_cnt - mbase, 4);
    check("bp_not_empty", {31'd0, dct_block_empty}, 32'd0);
    rd_req = rd_req + 1;
    repeat (60) @(negedge clk);
    check("bp_accepted_after_read", mb_en_cnt - mbase, 5);
    repeat (40) @(negedge clk);
    check("bp_still_blocked", mb_en_cnt - mbase, 5);
    rd_on = 1'b1;
    wait_drain("backpressure", 1500);
    check("bp_accepted_total", mb_en_cnt - mbase, 10);
    check("bp_drained_empty", {31'd0, dct_block_empty}, 32'd1);

    // Asynchronous reset between WR_L and WR_CB
    rd_on = 1'b0;
    push(1, 0);
    wait_mb_en("rstmid", 20);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_empty", {31'd0, dct_block_empty}, 32'd1);
    check("rstmid_valid", {31'd0, dct_block_valid}, 32'd0);
    check("rstmid_cmd", {29'd0, dct_block_cmd}, 32'd0);
    check("rstmid_mb_en", {31'd0, mb_en}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_post_empty", {31'd0, dct_block_empty}, 32'd1);
    base = got_q.size();
    rd_on = 1'b1;
    push(1, 1);
    wait_drain("rstmid", 200);
    want = '{L4_PASS, C1_F2T, C1_F2T};
    check_seq("rstmid", base);

    // Randomized traffic
    en_rand = 1'b1;
    rd_pct = 60;
    late = int'($urandom_range(2));
    mbase = mb_en_cnt;
    for (int i = 0; i < 30; i++) push(1'($urandom_range(1)), 1'($urandom_range(1)));
    wait_drain("random", 6000);
    check("random_mb_en_pulses", mb_en_cnt - mbase, 30);
    en_rand = 1'b0;
    late = 0;
    repeat (5) @(negedge clk);
    check("final_empty", {31'd0, dct_block_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish within 400000 ns");
    $fatal(1, "watchdog");
  end

endmodule
